// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor
//   Bridges the cache's whole-line memory port to a burst memory. One line
//   read or write becomes BEATS = LINE_W/BURST_W burst transfers. The cache
//   sees a single-cycle resp_o when the whole line has been moved.
//
// Ports
//   clk, rst         clock; synchronous active-low reset
//   address_i        line address from the cache (aligned before use)
//   read_i, write_i  line requests; write wins when both are high
//   line_i           line to write, captured when the request is accepted
//   line_o           assembled read line, valid in the resp_o cycle and held
//   resp_o           one-cycle completion pulse to the cache
//   address_o        line-aligned address held for the whole burst
//   read_o, write_o  burst request to memory, high for the whole burst
//   burst_o          current write beat (zero outside a write burst)
//   burst_i          incoming read beat
//   resp_i           beat strobe from memory: read data valid / write beat taken
//
// Handshake: a beat completes on every rising edge where read_o or write_o is
// high and resp_i is high. resp_i may have any number of idle gaps. The cache
// holds its request stable until it sees resp_o and drops it in that cycle.
//
// The FSM state is held in the signal "state" (state_t) for observation.
module cacheline_adaptor #(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 256,
    parameter int BURST_W = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  address_i,
    input  logic               read_i,
    input  logic               write_i,
    input  logic [LINE_W-1:0]  line_i,
    output logic [LINE_W-1:0]  line_o,
    output logic               resp_o,
    output logic [ADDR_W-1:0]  address_o,
    output logic               read_o,
    output logic               write_o,
    output logic [BURST_W-1:0] burst_o,
    input  logic [BURST_W-1:0] burst_i,
    input  logic               resp_i
);

    localparam int BEATS = LINE_W / BURST_W;
    localparam int CNT_W = $clog2(BEATS);
    localparam int OFF_W = $clog2(LINE_W / 8);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [LINE_W-1:0] wr_line;
    logic              last_beat;
    logic [ADDR_W-1:0] aligned_addr;

    // Drop the byte-within-line offset so memory always sees a line address.
    assign aligned_addr = {address_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    // Only meaningful in READ/WRITE, where it ends the burst.
    assign last_beat = resp_i && (cnt == CNT_W'(BEATS - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (write_i) begin
                    state_next = WRITE;
                end else if (read_i) begin
                    state_next = READ;
                end
            end
            READ:    if (last_beat) state_next = DONE;
            WRITE:   if (last_beat) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        read_o  = (state == READ);
        write_o = (state == WRITE);
        resp_o  = (state == DONE);
        burst_o = '0;
        if (state == WRITE) begin
            burst_o = wr_line[cnt*BURST_W +: BURST_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt       <= '0;
            wr_line   <= '0;
            line_o    <= '0;
            address_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (write_i) begin
                        wr_line   <= line_i;
                        address_o <= aligned_addr;
                    end else if (read_i) begin
                        address_o <= aligned_addr;
                    end
                end
                READ: begin
                    if (resp_i) begin
                        line_o[cnt*BURST_W +: BURST_W] <= burst_i;
                        cnt <= last_beat ? '0 : cnt + CNT_W'(1);
                    end
                end
                WRITE: begin
                    if (resp_i) begin
                        cnt <= last_beat ? '0 : cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cacheline_adaptor.sv
module tb_cacheline_adaptor;

  localparam int ADDR_W     = 32;
  localparam int LINE_W     = 256;
  localparam int BURST_W    = 64;
  localparam int BEATS      = LINE_W / BURST_W;
  localparam int LINE_BYTES = LINE_W / 8;

  logic               clk;
  logic               rst;
  logic [ADDR_W-1:0]  address_i;
  logic               read_i;
  logic               write_i;
  logic [LINE_W-1:0]  line_i;
  logic [LINE_W-1:0]  line_o;
  logic               resp_o;
  logic [ADDR_W-1:0]  address_o;
  logic               read_o;
  logic               write_o;
  logic [BURST_W-1:0] burst_o;
  logic [BURST_W-1:0] burst_i;
  logic               resp_i;

  int n_checks = 0;
  int n_errors = 0;

  // last read line the cache should be seeing on line_o
  logic [LINE_W-1:0]  held_line;
  // expected write beats, in the order memory must receive them
  logic [BURST_W-1:0] exp_q[$];

  cacheline_adaptor #(
    .ADDR_W (ADDR_W),
    .LINE_W (LINE_W),
    .BURST_W(BURST_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .address_i(address_i),
    .read_i   (read_i),
    .write_i  (write_i),
    .line_i   (line_i),
    .line_o   (line_o),
    .resp_o   (resp_o),
    .address_o(address_o),
    .read_o   (read_o),
    .write_o  (write_o),
    .burst_o  (burst_o),
    .burst_i  (burst_i),
    .resp_i   (resp_i)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [LINE_W-1:0] got,
                       input logic [LINE_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] l;
    l = '0;
    for (int i = 0; i < LINE_W / 32; i++) l = (l << 32) | LINE_W'($urandom);
    return l;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_resp"},  resp_o,  1'b0);
    check({tag, "_read"},  read_o,  1'b0);
    check({tag, "_write"}, write_o, 1'b0);
  endtask

  // ---------------- driver + reference model ----------------
  // Runs one whole line transfer. mem_line is what memory returns on a read;
  // wr_line is what the cache writes. gap_pat bit (c-1) gives resp_i in the
  // c-th cycle after acceptance when use_pat is set, else gaps are random.
  task automatic run_xfer(input bit do_wr, input bit both,
                          input logic [ADDR_W-1:0] addr,
                          input logic [LINE_W-1:0] wr_line,
                          input logic [LINE_W-1:0] mem_line,
                          input logic [31:0] gap_pat, input bit use_pat);
    logic [ADDR_W-1:0]  exp_addr;
    logic [BURST_W-1:0] exp_beat;
    bit                 is_wr;
    bit                 r;
    bit                 got_resp;
    int                 k;
    int                 cyc;
    int                 last_cyc;
    is_wr    = do_wr || both;
    exp_addr = (addr / LINE_BYTES) * LINE_BYTES;
    exp_q.delete();
    for (int i = 0; i < BEATS; i++) exp_q.push_back(BURST_W'(wr_line >> (i * BURST_W)));

    @(negedge clk);
    read_i    = !do_wr || both;
    write_i   = is_wr;
    address_i = addr;
    line_i    = wr_line;
    @(posedge clk);

    k = 0; cyc = 0; last_cyc = 0; got_resp = 0;
    while (cyc < 200 && !got_resp) begin
      @(negedge clk);
      cyc++;
      if (resp_o) begin
        got_resp = 1;
      end else begin
        check("burst_read_o",  read_o,  !is_wr);
        check("burst_write_o", write_o, is_wr);
        check("burst_addr",    address_o, exp_addr);
        r = use_pat ? ((cyc <= 32) ? gap_pat[cyc-1] : 1'b1) : ($urandom_range(0, 3) != 0);
        if (k >= BEATS) r = 0;
        resp_i  = r;
        burst_i = r ? BURST_W'(mem_line >> (k * BURST_W)) : BURST_W'($urandom);
        if (r && is_wr) begin
          exp_beat = exp_q.pop_front();
          check("write_beat", burst_o, exp_beat);
        end
        if (r) begin
          k++;
          last_cyc = cyc;
        end
      end
    end

    // resp_o cycle
    resp_i = 0;
    check("resp_seen", got_resp, 1'b1);
    check("beats_before_resp", k, BEATS);
    check("resp_latency", cyc, last_cyc + 1);
    check("done_read_o",  read_o,  1'b0);
    check("done_write_o", write_o, 1'b0);
    if (!is_wr) held_line = mem_line;
    check("line_o_done", line_o, held_line);
    read_i  = 0;
    write_i = 0;

    @(negedge clk);
    check_idle_outputs("after_done");
    check("line_o_hold", line_o, held_line);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [LINE_W-1:0] l_a;
    logic [LINE_W-1:0] l_b;
    logic [LINE_W-1:0] zero_line;
    zero_line = '0;
    rst = 0; read_i = 0; write_i = 0; address_i = '0; line_i = '0;
    burst_i = '0; resp_i = 0; held_line = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    check("reset_addr",  address_o, 32'h0);
    check("reset_burst", burst_o,   64'h0);
    check("reset_line",  line_o,    zero_line);
    rst = 1;

    // read with no gaps
    l_a = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    run_xfer(0, 0, 32'h0000_1234, zero_line, l_a, 32'hFFFF_FFFF, 1);
    check("nogap_addr_const", (32'h0000_1234 / LINE_BYTES) * LINE_BYTES, 32'h0000_1220);

    // write A,B,C,D
    l_b = {64'hD, 64'hC, 64'hB, 64'hA};
    run_xfer(1, 0, 32'h8000_0040, l_b, rand_line(), 32'hFFFF_FFFF, 1);

    // gapped read: 1,0,0,1,1,0,1
    run_xfer(0, 0, 32'h0000_2A7F, zero_line, rand_line(), 32'h0000_0059, 1);

    // read and write together: write path wins
    run_xfer(0, 1, 32'h1234_5678, rand_line(), rand_line(), 32'hFFFF_FFFF, 1);

    // reset in the middle of a read, after two beats
    @(negedge clk);
    read_i = 1; address_i = 32'h0000_0100;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      resp_i = 1; burst_i = 64'hDEAD_BEEF_0000_0000 | 64'(i);
    end
    @(negedge clk);
    resp_i = 0; read_i = 0; rst = 0;
    @(negedge clk);
    rst = 1;
    check_idle_outputs("midreset");
    check("midreset_line", line_o, zero_line);
    held_line = '0;
    run_xfer(0, 0, 32'h0000_0100, zero_line, rand_line(), 32'h0000_0000, 0);

    // spurious resp_i while idle
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      resp_i = 1; burst_i = BURST_W'($urandom);
      @(negedge clk);
      check_idle_outputs("spurious");
      check("spurious_line", line_o, held_line);
    end
    resp_i = 0;
    run_xfer(0, 0, 32'h0000_0040, zero_line, rand_line(), 32'hFFFF_FFFF, 1);

    // randomized transfers
    for (int t = 0; t < 25; t++) begin
      run_xfer(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 3) == 0),
               ADDR_W'($urandom), rand_line(), rand_line(), 32'h0, 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
